// File: rtl/bfis_ctrl_pkg.sv
// bfis_ctrl_pkg
//   Shared definitions for the bfis host query controller:
//   - state_e   : controller FSM states
//   - HDR_TAG   : tag byte in the response frame header
//   - ERR_TAG   : upper half of the bad-k error word
//   - hdr_pack  : builds the response header word
package bfis_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LAUNCH,
        RUN,
        DRAIN,
        ERR
    } state_e;

    localparam logic [7:0]  HDR_TAG = 8'hA5;
    localparam logic [15:0] ERR_TAG = 16'hEEEE;

    // Header layout: {tag, 7'b0, timeout flag, result count}
    function automatic logic [31:0] hdr_pack(input logic timeout, input logic [15:0] n);
        return {HDR_TAG, 7'b0, timeout, n};
    endfunction

endpackage

// File: rtl/bfis_query_ctrl_result_buf.sv
// result_buf
//   Register file holding the top-k result words returned by the engine.
//   Ports:
//     clk_i    : clock
//     rst_ni   : synchronous active-low reset (clears all entries)
//     we_i     : write enable
//     waddr_i  : write index
//     wdata_i  : write data
//     raddr_i  : read index (asynchronous read)
//     rdata_o  : read data
module result_buf
    import bfis_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q <= '{default: '0};
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bfis_query_ctrl.sv
// bfis_query_ctrl
//   Host-side sequencer for the bfis search engine. Parses a framed host
//   word stream (sync, DIM query words, k, entry vertex), launches one
//   search, collects k results with a cycle count and timeout, then
//   streams a response frame (header, results, cycle count) to the host.
//   Ports:
//     clk_in, rst_in          : clock, synchronous active-low reset
//     rx_data_in/valid/ready  : host request stream
//     eng_query/k/vertex_id   : launch arguments, held from LAUNCH onward
//     eng_valid_out           : one-cycle launch pulse
//     eng_result_in/valid_in  : result words from the engine
//     tx_data/valid/ready     : response stream
//     busy_out                : high whenever not IDLE
module bfis_query_ctrl
    import bfis_ctrl_pkg::*;
#(
    parameter int unsigned DIM         = 4,
    parameter int unsigned K_MAX       = 8,
    parameter logic [31:0] SYNC_WORD   = 32'hFFFF_FFFF,
    parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] rx_data_in,
    input  logic        rx_valid_in,
    output logic        rx_ready_out,
    output logic [31:0] eng_query_out [DIM],
    output logic [15:0] eng_k_out,
    output logic [31:0] eng_vertex_id_out,
    output logic        eng_valid_out,
    input  logic [31:0] eng_result_in,
    input  logic        eng_result_valid_in,
    output logic [31:0] tx_data_out,
    output logic        tx_valid_out,
    input  logic        tx_ready_in,
    output logic        busy_out
);

    localparam int unsigned WCW = $clog2(DIM + 2);
    localparam int unsigned RCW = $clog2(K_MAX + 1);
    localparam int unsigned PW  = $clog2(K_MAX + 2);
    localparam int unsigned AW  = (K_MAX > 1) ? $clog2(K_MAX) : 1;

    state_e            state_q, state_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic [31:0]       qstg_q [DIM];
    logic [31:0]       qstg_d [DIM];
    logic [15:0]       kstg_q, kstg_d;
    logic [31:0]       query_q [DIM];
    logic [31:0]       query_d [DIM];
    logic [15:0]       keng_q, keng_d;
    logic [31:0]       vid_q, vid_d;
    logic [31:0]       cyc_q, cyc_d;
    logic [RCW-1:0]    rcnt_q, rcnt_d;
    logic              tmo_q, tmo_d;
    logic [PW-1:0]     dptr_q, dptr_d;

    logic              accept;
    logic [RCW-1:0]    rcnt_inc;
    logic              buf_we;
    logic [AW-1:0]     buf_raddr;
    logic [31:0]       buf_rdata;

    result_buf #(
        .DEPTH (K_MAX),
        .AW    (AW)
    ) u_result_buf (
        .clk_i   (clk_in),
        .rst_ni  (rst_in),
        .we_i    (buf_we),
        .waddr_i (AW'(rcnt_q)),
        .wdata_i (eng_result_in),
        .raddr_i (buf_raddr),
        .rdata_o (buf_rdata)
    );

    // Ready is masked by reset so every output reads 0 while reset is held.
    assign rx_ready_out      = rst_in && ((state_q == IDLE) || (state_q == LOAD));
    assign accept            = rx_valid_in && rx_ready_out;
    assign busy_out          = (state_q != IDLE);
    assign eng_query_out     = query_q;
    assign eng_k_out         = keng_q;
    assign eng_vertex_id_out = vid_q;

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        qstg_d        = qstg_q;
        kstg_d        = kstg_q;
        query_d       = query_q;
        keng_d        = keng_q;
        vid_d         = vid_q;
        cyc_d         = cyc_q;
        rcnt_d        = rcnt_q;
        tmo_d         = tmo_q;
        dptr_d        = dptr_q;
        rcnt_inc      = rcnt_q + RCW'(1);
        buf_we        = 1'b0;
        buf_raddr     = AW'(dptr_q - PW'(1));
        eng_valid_out = 1'b0;
        tx_valid_out  = 1'b0;
        tx_data_out   = '0;

        unique case (state_q)
            IDLE: begin
                if (accept && (rx_data_in == SYNC_WORD)) begin
                    state_d = LOAD;
                    wcnt_d  = '0;
                end
            end

            LOAD: begin
                if (accept) begin
                    if (rx_data_in == SYNC_WORD) begin
                        wcnt_d = '0;
                    end else if (wcnt_q < WCW'(DIM)) begin
                        for (int unsigned i = 0; i < DIM; i++) begin
                            if (wcnt_q == WCW'(i)) begin
                                qstg_d[i] = rx_data_in;
                            end
                        end
                        wcnt_d = wcnt_q + WCW'(1);
                    end else if (wcnt_q == WCW'(DIM)) begin
                        kstg_d = rx_data_in[15:0];
                        wcnt_d = wcnt_q + WCW'(1);
                    end else begin
                        // Vertex id is the final word: validate k, then latch
                        // the launch arguments straight from staging.
                        if ((kstg_q == '0) || (kstg_q > 16'(K_MAX))) begin
                            state_d = ERR;
                        end else begin
                            state_d = LAUNCH;
                            query_d = qstg_q;
                            keng_d  = kstg_q;
                            vid_d   = rx_data_in;
                        end
                    end
                end
            end

            LAUNCH: begin
                eng_valid_out = 1'b1;
                cyc_d         = '0;
                rcnt_d        = '0;
                tmo_d         = 1'b0;
                state_d       = RUN;
            end

            RUN: begin
                cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;
                if (eng_result_valid_in) begin
                    buf_we = 1'b1;
                    rcnt_d = rcnt_inc;
                    if (16'(rcnt_inc) == keng_q) begin
                        state_d = DRAIN;
                        dptr_d  = '0;
                    end
                end
                // Final result takes priority over a coincident timeout.
                if ((state_d == RUN) && (cyc_d >= TIMEOUT_CYC)) begin
                    state_d = DRAIN;
                    tmo_d   = 1'b1;
                    dptr_d  = '0;
                end
            end

            DRAIN: begin
                tx_valid_out = 1'b1;
                if (dptr_q == '0) begin
                    tx_data_out = hdr_pack(tmo_q, 16'(rcnt_q));
                end else if (dptr_q <= PW'(rcnt_q)) begin
                    tx_data_out = buf_rdata;
                end else begin
                    tx_data_out = cyc_q;
                end
                if (tx_ready_in) begin
                    if (dptr_q == PW'(rcnt_q) + PW'(1)) begin
                        state_d = IDLE;
                    end else begin
                        dptr_d = dptr_q + PW'(1);
                    end
                end
            end

            ERR: begin
                tx_valid_out = 1'b1;
                tx_data_out  = {ERR_TAG, kstg_q};
                if (tx_ready_in) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            qstg_q  <= '{default: '0};
            kstg_q  <= '0;
            query_q <= '{default: '0};
            keng_q  <= '0;
            vid_q   <= '0;
            cyc_q   <= '0;
            rcnt_q  <= '0;
            tmo_q   <= 1'b0;
            dptr_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            qstg_q  <= qstg_d;
            kstg_q  <= kstg_d;
            query_q <= query_d;
            keng_q  <= keng_d;
            vid_q   <= vid_d;
            cyc_q   <= cyc_d;
            rcnt_q  <= rcnt_d;
            tmo_q   <= tmo_d;
            dptr_q  <= dptr_d;
        end
    end

endmodule

// File: tb/tb_bfis_query_ctrl.sv
module tb_bfis_query_ctrl;

    localparam logic [31:0] SYNC = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_in;
    logic [31:0] rx_data_in;
    logic        rx_valid_in;
    logic        rx_ready_out;
    logic [31:0] eng_query_out [4];
    logic [15:0] eng_k_out;
    logic [31:0] eng_vertex_id_out;
    logic        eng_valid_out;
    logic [31:0] eng_result_in;
    logic        eng_result_valid_in;
    logic [31:0] tx_data_out;
    logic        tx_valid_out;
    logic        tx_ready_in;
    logic        busy_out;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_tx[$];
    int          launch_cnt = 0;
    logic [31:0] l_q [4];
    logic [15:0] l_k;
    logic [31:0] l_vid;

    int          sch_n;
    int          sch_cyc [8];
    logic [31:0] sch_val [8];

    always #5 clk = ~clk;

    bfis_query_ctrl #(
        .DIM         (4),
        .K_MAX       (8),
        .SYNC_WORD   (32'hFFFF_FFFF),
        .TIMEOUT_CYC (32'd50)
    ) dut (
        .clk_in              (clk),
        .rst_in              (rst_in),
        .rx_data_in          (rx_data_in),
        .rx_valid_in         (rx_valid_in),
        .rx_ready_out        (rx_ready_out),
        .eng_query_out       (eng_query_out),
        .eng_k_out           (eng_k_out),
        .eng_vertex_id_out   (eng_vertex_id_out),
        .eng_valid_out       (eng_valid_out),
        .eng_result_in       (eng_result_in),
        .eng_result_valid_in (eng_result_valid_in),
        .tx_data_out         (tx_data_out),
        .tx_valid_out        (tx_valid_out),
        .tx_ready_in         (tx_ready_in),
        .busy_out            (busy_out)
    );

    // Scoreboard side: every accepted response word is popped against the
    // expectation queue; launches are logged for the tests to inspect.
    always @(negedge clk) begin
        logic [31:0] ew;
        if (tx_valid_out && tx_ready_in) begin
            checks++;
            if (exp_tx.size() == 0) begin
                failures++;
                $display("FAIL tx_unexpected got=%h required=none", tx_data_out);
            end else begin
                ew = exp_tx.pop_front();
                if (tx_data_out !== ew) begin
                    failures++;
                    $display("FAIL tx_word got=%h required=%h", tx_data_out, ew);
                end
            end
        end
        if (eng_valid_out === 1'b1) begin
            launch_cnt++;
            l_q   = eng_query_out;
            l_k   = eng_k_out;
            l_vid = eng_vertex_id_out;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send_word(input logic [31:0] w);
        rx_data_in  = w;
        rx_valid_in = 1'b1;
        @(posedge clk); #1;
        rx_valid_in = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] q0, q1, q2, q3, k, vid);
        send_word(SYNC);
        send_word(q0); send_word(q1); send_word(q2); send_word(q3);
        send_word(k);
        send_word(vid);
    endtask

    // Engine model: called in the LAUNCH cycle; cycle c is the c-th RUN cycle.
    task automatic run_engine(input int ncyc);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            eng_result_valid_in = 1'b0;
            for (int s = 0; s < sch_n; s++) begin
                if (sch_cyc[s] == c) begin
                    eng_result_valid_in = 1'b1;
                    eng_result_in       = sch_val[s];
                end
            end
        end
        @(posedge clk); #1;
        eng_result_valid_in = 1'b0;
    endtask

    task automatic set_nominal_sched(input logic [31:0] base);
        sch_n = 4;
        for (int s = 0; s < 4; s++) begin
            sch_cyc[s] = s + 3;
            sch_val[s] = base * (s + 1);
        end
    endtask

    task automatic test_reset;
        rst_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", busy_out); end
        checks++; if (tx_valid_out !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b required=0", tx_valid_out); end
        checks++; if (eng_valid_out !== 1'b0) begin failures++; $display("FAIL reset_eng_valid got=%b required=0", eng_valid_out); end
        checks++; if (eng_k_out !== 16'h0 || eng_vertex_id_out !== 32'h0) begin
            failures++; $display("FAIL reset_eng_args got k=%h vid=%h required=0", eng_k_out, eng_vertex_id_out);
        end
        rst_in = 1'b1;
        @(posedge clk); #1;
        checks++; if (rx_ready_out !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b required=1", rx_ready_out); end
    endtask

    task automatic test_nominal;
        int l0 = launch_cnt;
        exp_tx.push_back(32'hA500_0004);
        exp_tx.push_back(32'h10); exp_tx.push_back(32'h20);
        exp_tx.push_back(32'h30); exp_tx.push_back(32'h40);
        exp_tx.push_back(32'd6);
        set_nominal_sched(32'h10);
        send_frame(5, 7, 1, 1, 4, 1);
        checks++; if (eng_valid_out !== 1'b1) begin failures++; $display("FAIL launch_latency got=%b required=1", eng_valid_out); end
        run_engine(6);
        for (int i = 0; i < 100 && exp_tx.size() != 0; i++) begin @(posedge clk); #1; end
        checks++; if (exp_tx.size() != 0) begin failures++; $display("FAIL nominal_drain_timeout got=%0d left required=0", exp_tx.size()); end
        checks++; if (launch_cnt - l0 != 1) begin failures++; $display("FAIL nominal_launches got=%0d required=1", launch_cnt - l0); end
        checks++; if (l_q[0] !== 32'd5 || l_q[1] !== 32'd7 || l_q[2] !== 32'd1 || l_q[3] !== 32'd1) begin
            failures++; $display("FAIL nominal_query got=%h %h %h %h required=5 7 1 1", l_q[0], l_q[1], l_q[2], l_q[3]);
        end
        checks++; if (l_k !== 16'd4 || l_vid !== 32'd1) begin failures++; $display("FAIL nominal_k_vid got=%h/%h required=4/1", l_k, l_vid); end
        checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL nominal_idle_busy got=%b required=0", busy_out); end
        checks++; if (eng_k_out !== 16'd4) begin failures++; $display("FAIL nominal_k_held got=%h required=4", eng_k_out); end
    endtask

    task automatic test_resync;
        int l0 = launch_cnt;
        exp_tx.push_back(32'hA500_0003);
        exp_tx.push_back(32'hA1); exp_tx.push_back(32'hA2); exp_tx.push_back(32'hA3);
        exp_tx.push_back(32'd3);
        sch_n = 3;
        for (int s = 0; s < 3; s++) begin sch_cyc[s] = s + 1; sch_val[s] = 32'hA1 + 32'(s); end
        send_word(32'h3); send_word(32'h1234);
        send_word(SYNC); send_word(5); send_word(7);
        send_word(SYNC); send_word(2); send_word(2); send_word(2); send_word(2);
        send_word(3); send_word(9);
        run_engine(3);
        for (int i = 0; i < 100 && exp_tx.size() != 0; i++) begin @(posedge clk); #1; end
        checks++; if (exp_tx.size() != 0) begin failures++; $display("FAIL resync_drain_timeout got=%0d left required=0", exp_tx.size()); end
        checks++; if (launch_cnt - l0 != 1) begin failures++; $display("FAIL resync_launches got=%0d required=1", launch_cnt - l0); end
        checks++; if (l_q[0] !== 32'd2 || l_q[1] !== 32'd2 || l_q[2] !== 32'd2 || l_q[3] !== 32'd2) begin
            failures++; $display("FAIL resync_query got=%h %h %h %h required=2 2 2 2", l_q[0], l_q[1], l_q[2], l_q[3]);
        end
        checks++; if (l_k !== 16'd3 || l_vid !== 32'd9) begin failures++; $display("FAIL resync_k_vid got=%h/%h required=3/9", l_k, l_vid); end
    endtask

    task automatic test_bad_k;
        int l0 = launch_cnt;
        exp_tx.push_back(32'hEEEE_0000);
        send_frame(1, 2, 3, 4, 0, 5);
        for (int i = 0; i < 50 && exp_tx.size() != 0; i++) begin @(posedge clk); #1; end
        checks++; if (exp_tx.size() != 0) begin failures++; $display("FAIL badk0_timeout got=%0d left required=0", exp_tx.size()); end
        exp_tx.push_back(32'hEEEE_0009);
        send_frame(1, 2, 3, 4, 9, 5);
        for (int i = 0; i < 50 && exp_tx.size() != 0; i++) begin @(posedge clk); #1; end
        checks++; if (exp_tx.size() != 0) begin failures++; $display("FAIL badk9_timeout got=%0d left required=0", exp_tx.size()); end
        checks++; if (launch_cnt != l0) begin failures++; $display("FAIL badk_launches got=%0d required=0", launch_cnt - l0); end
        checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL badk_idle got=%b required=0", busy_out); end
    endtask

    task automatic test_timeout;
        // Two of four results, then a stray result during DRAIN.
        exp_tx.push_back(32'hA501_0002);
        exp_tx.push_back(32'h11); exp_tx.push_back(32'h22);
        exp_tx.push_back(32'd50);
        sch_n = 3;
        sch_cyc[0] = 2;  sch_val[0] = 32'h11;
        sch_cyc[1] = 5;  sch_val[1] = 32'h22;
        sch_cyc[2] = 52; sch_val[2] = 32'h99;
        send_frame(1, 1, 1, 1, 4, 3);
        run_engine(56);
        for (int i = 0; i < 100 && exp_tx.size() != 0; i++) begin @(posedge clk); #1; end
        checks++; if (exp_tx.size() != 0) begin failures++; $display("FAIL timeout_drain got=%0d left required=0", exp_tx.size()); end
        // Final result lands exactly on the timeout cycle: no timeout flag.
        exp_tx.push_back(32'hA500_0001);
        exp_tx.push_back(32'h33);
        exp_tx.push_back(32'd50);
        sch_n = 1; sch_cyc[0] = 50; sch_val[0] = 32'h33;
        send_frame(1, 1, 1, 1, 1, 3);
        run_engine(50);
        for (int i = 0; i < 100 && exp_tx.size() != 0; i++) begin @(posedge clk); #1; end
        checks++; if (exp_tx.size() != 0) begin failures++; $display("FAIL coincide_drain got=%0d left required=0", exp_tx.size()); end
    endtask

    task automatic test_backpressure;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_data  = '0;
        int          stall_checks = 0;
        int          j = 0;
        tx_ready_in = 1'b0;
        exp_tx.push_back(32'hA500_0004);
        exp_tx.push_back(32'h10); exp_tx.push_back(32'h20);
        exp_tx.push_back(32'h30); exp_tx.push_back(32'h40);
        exp_tx.push_back(32'd6);
        set_nominal_sched(32'h10);
        send_frame(5, 7, 1, 1, 4, 1);
        run_engine(6);
        while (exp_tx.size() != 0 && j < 200) begin
            tx_ready_in = (j >= 4 && j < 9) ? 1'b0 : ((j % 2) == 0);
            @(negedge clk);
            if (prev_stall) begin
                stall_checks++;
                checks++;
                if (tx_valid_out !== 1'b1 || tx_data_out !== prev_data) begin
                    failures++;
                    $display("FAIL stall_hold got=%b/%h required=1/%h", tx_valid_out, tx_data_out, prev_data);
                end
            end
            prev_stall = tx_valid_out && !tx_ready_in;
            prev_data  = tx_data_out;
            @(posedge clk); #1;
            j++;
        end
        tx_ready_in = 1'b1;
        checks++; if (exp_tx.size() != 0) begin failures++; $display("FAIL bp_drain_timeout got=%0d left required=0", exp_tx.size()); end
        checks++; if (stall_checks < 5) begin failures++; $display("FAIL bp_stalls got=%0d required>=5", stall_checks); end
    endtask

    task automatic test_reset_mid_run;
        send_frame(5, 7, 1, 1, 4, 1);
        @(posedge clk); #1;
        eng_result_valid_in = 1'b1; eng_result_in = 32'hAA;
        @(posedge clk); #1;
        eng_result_in = 32'hBB;
        @(posedge clk); #1;
        eng_result_valid_in = 1'b0;
        rst_in = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy_out !== 1'b0 || tx_valid_out !== 1'b0 || eng_valid_out !== 1'b0 || rx_ready_out !== 1'b0) begin
            failures++; $display("FAIL midrst_ctrl got busy=%b txv=%b engv=%b rdy=%b required=0000", busy_out, tx_valid_out, eng_valid_out, rx_ready_out);
        end
        checks++; if (eng_k_out !== 16'h0 || eng_vertex_id_out !== 32'h0 || eng_query_out[0] !== 32'h0 || tx_data_out !== 32'h0) begin
            failures++; $display("FAIL midrst_data got k=%h vid=%h q0=%h tx=%h required=0", eng_k_out, eng_vertex_id_out, eng_query_out[0], tx_data_out);
        end
        rst_in = 1'b1;
        @(posedge clk); #1;
        exp_tx.push_back(32'hA500_0004);
        exp_tx.push_back(32'h1); exp_tx.push_back(32'h2);
        exp_tx.push_back(32'h3); exp_tx.push_back(32'h4);
        exp_tx.push_back(32'd6);
        set_nominal_sched(32'h1);
        send_frame(5, 7, 1, 1, 4, 1);
        run_engine(6);
        for (int i = 0; i < 100 && exp_tx.size() != 0; i++) begin @(posedge clk); #1; end
        checks++; if (exp_tx.size() != 0) begin failures++; $display("FAIL midrst_drain got=%0d left required=0", exp_tx.size()); end
    endtask

    initial begin
        rst_in              = 1'b0;
        rx_data_in          = '0;
        rx_valid_in         = 1'b0;
        eng_result_in       = '0;
        eng_result_valid_in = 1'b0;
        tx_ready_in         = 1'b1;
        sch_n               = 0;
        test_reset;
        test_nominal;
        test_resync;
        test_bad_k;
        test_timeout;
        test_backpressure;
        test_reset_mid_run;
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
